// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, reset PC and the
// position of the branch/jump word offset inside the instruction.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  localparam int OFFSET_LSB = 16;
  localparam int OFFSET_MSB = 23;
  localparam int OFFSET_W_DEFAULT = OFFSET_MSB - OFFSET_LSB + 1;

endpackage

// File: rtl/pc_next_logic.sv
// Stateless next-PC arithmetic: sequential address, branch/jump target and
// the taken decision for the current instruction.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_DEFAULT
) (
  input  logic [31:0]         pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero,
  output logic [31:0]         pc_plus4,
  output logic [31:0]         target,
  output logic                taken
);

  logic [31:0] byte_offset_s;

  // Word offset becomes a signed byte displacement; all sums wrap modulo 2^32.
  assign byte_offset_s = {{(32-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
  assign pc_plus4      = pc + 32'd4;
  assign target        = pc_plus4 + byte_offset_s;
  assign taken         = jump | (branch & zero);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, holds it across memory busywait
// and remembers a taken redirect decided in the cycle the stall began.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          OFFSET_W = OFFSET_W_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                JUMP,
  input  logic                BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  input  logic                I_BUSYWAIT,
  input  logic                D_BUSYWAIT,
  output logic [31:0]         PC,
  output logic [31:0]         PC_PLUS4,
  output logic                FETCH_EN,
  output logic                STALL,
  output logic                REDIRECT,
  output logic [31:0]         RETIRED
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        pend_taken_q, pend_taken_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        taken_s;
  logic        busy_s;

  pc_next_logic #(
    .OFFSET_W (OFFSET_W)
  ) u_next (
    .pc       (pc_q),
    .offset   (OFFSET),
    .jump     (JUMP),
    .branch   (BRANCH),
    .zero     (ZERO),
    .pc_plus4 (pc_plus4_s),
    .target   (target_s),
    .taken    (taken_s)
  );

  assign busy_s = I_BUSYWAIT | D_BUSYWAIT;

  // Next-state, next-PC and pending-redirect selection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    retired_d     = retired_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (busy_s) begin
          state_d       = ST_STALL;
          pend_taken_d  = taken_s;
          pend_target_d = target_s;
        end else begin
          pc_d      = taken_s ? target_s : pc_plus4_s;
          retired_d = retired_q + 32'd1;
        end
      end
      ST_STALL: begin
        // Flow inputs are ignored here; the decision was captured on entry.
        if (busy_s) begin
          state_d = ST_STALL;
        end else begin
          pc_d         = pend_taken_q ? pend_target_q : pc_plus4_s;
          retired_d    = retired_q + 32'd1;
          state_d      = ST_RUN;
          pend_taken_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_BOOT;
        pc_d         = RESET_PC;
        pend_taken_d = 1'b0;
      end
    endcase
  end

  // State, PC, retire counter and pending-redirect registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      retired_q     <= 32'd0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      retired_q     <= retired_d;
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_plus4_s;
  assign RETIRED  = retired_q;
  assign FETCH_EN = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign STALL    = (state_q == ST_STALL);
  assign REDIRECT = ((state_q == ST_RUN) && taken_s) ||
                    ((state_q == ST_STALL) && pend_taken_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branches, jumps, stalls with a
// pending redirect, overlapping busywaits, reset mid-stall and PC wrap.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        JUMP, BRANCH, ZERO;
  logic [7:0]  OFFSET;
  logic        I_BUSYWAIT, D_BUSYWAIT;
  logic [31:0] PC, PC_PLUS4, RETIRED;
  logic        FETCH_EN, STALL, REDIRECT;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer #(.RESET_PC(32'd0), .OFFSET_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .JUMP       (JUMP),
    .BRANCH     (BRANCH),
    .ZERO       (ZERO),
    .OFFSET     (OFFSET),
    .I_BUSYWAIT (I_BUSYWAIT),
    .D_BUSYWAIT (D_BUSYWAIT),
    .PC         (PC),
    .PC_PLUS4   (PC_PLUS4),
    .FETCH_EN   (FETCH_EN),
    .STALL      (STALL),
    .REDIRECT   (REDIRECT),
    .RETIRED    (RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_flow(input logic j, input logic b, input logic z, input logic [7:0] off);
    JUMP = j; BRANCH = b; ZERO = z; OFFSET = off;
  endtask

  initial begin
    RESET = 1'b0;
    set_flow(1'b0, 1'b0, 1'b0, 8'h00);
    I_BUSYWAIT = 1'b0;
    D_BUSYWAIT = 1'b0;
    repeat (3) tick();

    check_eq("rst_pc",       PC,       32'h0);
    check_eq("rst_pc4",      PC_PLUS4, 32'h4);
    check_eq("rst_fetch",    {31'd0, FETCH_EN}, 32'd0);
    check_eq("rst_stall",    {31'd0, STALL},    32'd0);
    check_eq("rst_redirect", {31'd0, REDIRECT}, 32'd0);
    check_eq("rst_retired",  RETIRED,  32'd0);

    RESET = 1'b1;
    #1;
    check_eq("boot_fetch", {31'd0, FETCH_EN}, 32'd0);
    tick();
    check_eq("boot_pc_hold", PC, 32'h0);
    check_eq("run_fetch", {31'd0, FETCH_EN}, 32'd1);
    tick();
    check_eq("seq_pc4", PC, 32'h4);
    tick();
    check_eq("seq_pc8", PC, 32'h8);
    check_eq("seq_retired", RETIRED, 32'd2);

    // 0x08 -> 0x10 via forward jump of one word
    set_flow(1'b1, 1'b0, 1'b0, 8'h01);
    #1 check_eq("jmp_redirect", {31'd0, REDIRECT}, 32'd1);
    tick();
    check_eq("jmp_fwd_pc", PC, 32'h10);

    set_flow(1'b0, 1'b1, 1'b0, 8'h02);
    #1 check_eq("bne_redirect", {31'd0, REDIRECT}, 32'd0);
    tick();
    check_eq("br_not_taken", PC, 32'h14);

    set_flow(1'b1, 1'b0, 1'b0, 8'hFE);
    tick();
    check_eq("jmp_back_to_10", PC, 32'h10);

    set_flow(1'b0, 1'b1, 1'b1, 8'h02);
    #1 check_eq("beq_redirect", {31'd0, REDIRECT}, 32'd1);
    tick();
    check_eq("br_taken", PC, 32'h1C);

    set_flow(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_eq("pc_20", PC, 32'h20);

    set_flow(1'b1, 1'b0, 1'b0, 8'hFE);
    tick();
    check_eq("jmp_backward", PC, 32'h1C);

    set_flow(1'b1, 1'b0, 1'b0, 8'h08);
    tick();
    check_eq("jmp_to_40", PC, 32'h40);
    check_eq("retired_9", RETIRED, 32'd9);

    // Stall with a pending jump; flow inputs glitch during the stall
    set_flow(1'b1, 1'b0, 1'b0, 8'h03);
    D_BUSYWAIT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_flow(1'b0, 1'b1, 1'b0, 8'h7F);
      #1;
      check_eq($sformatf("stall_pc_%0d", i), PC, 32'h40);
      check_eq($sformatf("stall_flag_%0d", i), {31'd0, STALL}, 32'd1);
      check_eq($sformatf("stall_redir_%0d", i), {31'd0, REDIRECT}, 32'd1);
    end
    set_flow(1'b0, 1'b0, 1'b0, 8'h00);
    D_BUSYWAIT = 1'b0;
    check_eq("stall_retired_hold", RETIRED, 32'd9);
    tick();
    check_eq("stall_resume_pc", PC, 32'h50);
    check_eq("stall_resume_ret", RETIRED, 32'd10);
    check_eq("stall_cleared", {31'd0, STALL}, 32'd0);
    check_eq("stall_redir_clr", {31'd0, REDIRECT}, 32'd0);

    // I busy for edges 1-2, D busy for edges 2-5: one 5-cycle stall
    for (int e = 1; e <= 5; e++) begin
      I_BUSYWAIT = (e <= 2);
      D_BUSYWAIT = (e >= 2);
      tick();
      check_eq($sformatf("ovl_pc_%0d", e), PC, 32'h50);
      check_eq($sformatf("ovl_stall_%0d", e), {31'd0, STALL}, 32'd1);
    end
    I_BUSYWAIT = 1'b0;
    D_BUSYWAIT = 1'b0;
    tick();
    check_eq("ovl_resume_pc", PC, 32'h54);
    check_eq("ovl_retired", RETIRED, 32'd11);

    // Busywait pulse that is low again before the edge is ignored
    I_BUSYWAIT = 1'b1;
    #2 I_BUSYWAIT = 1'b0;
    tick();
    check_eq("glitch_pc", PC, 32'h58);
    check_eq("glitch_stall", {31'd0, STALL}, 32'd0);

    // Reset asserted mid-stall with a pending target
    set_flow(1'b1, 1'b0, 1'b0, 8'h05);
    D_BUSYWAIT = 1'b1;
    tick();
    check_eq("pre_rst_stall", {31'd0, STALL}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_eq("midrst_pc", PC, 32'h0);
    check_eq("midrst_stall", {31'd0, STALL}, 32'd0);
    check_eq("midrst_fetch", {31'd0, FETCH_EN}, 32'd0);
    check_eq("midrst_retired", RETIRED, 32'd0);
    check_eq("midrst_redirect", {31'd0, REDIRECT}, 32'd0);
    @(negedge CLK);
    set_flow(1'b0, 1'b0, 1'b0, 8'h00);
    D_BUSYWAIT = 1'b0;
    RESET = 1'b1;
    tick();
    check_eq("reboot_pc", PC, 32'h0);
    tick();
    check_eq("reboot_seq", PC, 32'h4);
    check_eq("reboot_retired", RETIRED, 32'd1);

    // Wrap-around: jump to 0xFFFFFFFC, then fall through to zero
    set_flow(1'b1, 1'b0, 1'b0, 8'hFD);
    tick();
    check_eq("wrap_top_pc", PC, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", PC_PLUS4, 32'h0);
    set_flow(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_eq("wrap_pc", PC, 32'h0);

    // OFFSET = -1 word targets the current PC
    set_flow(1'b1, 1'b0, 1'b0, 8'hFF);
    tick();
    check_eq("self_jump_pc", PC, 32'h0);
    check_eq("self_jump_ret", RETIRED, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequential program-counter controller for the single-cycle CPU. It owns the PC register and computes the next PC as PC+4 or the jump/branch target. It holds the PC while instruction or data memory asserts busywait, and remembers a taken jump/branch across the stall. It sits between the control unit / ALU ZERO flag and the instruction memory address port.

## Interface
Parameters:
- RESET_PC, 32'd0: PC value loaded on reset.
- OFFSET_W, 8: width of the signed word offset from the instruction.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RESET  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- JUMP  in  1  current instruction is an unconditional jump.
- BRANCH  in  1  current instruction is a branch-if-equal.
- ZERO  in  1  ALU zero flag for the current instruction.
- OFFSET  in  OFFSET_W  signed word offset (instruction bits [23:16]).
- I_BUSYWAIT  in  1  instruction memory not ready.
- D_BUSYWAIT  in  1  data memory not ready.
- PC  out  32  current instruction address (registered).
- PC_PLUS4  out  32  PC+4 (combinational).
- FETCH_EN  out  1  instruction memory read enable.
- STALL  out  1  high while the PC is held for busywait.
- REDIRECT  out  1  high in any cycle whose next PC is a target, not PC+4.
- RETIRED  out  32  count of instructions retired since reset.

## Operation
- Taken condition: TAKEN = JUMP | (BRANCH & ZERO).
- Target arithmetic: TARGET = PC_PLUS4 + {sign-extended OFFSET, 2'b00}, computed modulo 2^32.
- PC_PLUS4 is also computed modulo 2^32, so 32'hFFFFFFFC wraps to 0. OFFSET = 8'hFF gives TARGET = PC.
- The FSM has three states: BOOT, RUN, STALL.
- BOOT:
  - Entered on reset.
  - FETCH_EN=0. PC=RESET_PC.
  - The first rising edge with RESET high moves to RUN. PC does not change on that edge.
- RUN:
  - FETCH_EN=1.
  - BUSY is defined as I_BUSYWAIT | D_BUSYWAIT.
  - Edge with BUSY=0: PC becomes TAKEN ? TARGET : PC_PLUS4, and RETIRED increments.
  - Edge with BUSY=1: go to STALL, PC is held, and PEND_TAKEN / PEND_TARGET latch TAKEN / TARGET.
- STALL:
  - FETCH_EN=1, STALL=1.
  - Edge with BUSY=1: remain in STALL. The latched values are not overwritten, even if JUMP, BRANCH or ZERO glitch.
  - Edge with BUSY=0: PC becomes PEND_TAKEN ? PEND_TARGET : PC_PLUS4, RETIRED increments, go to RUN, and the pending flag clears.
- REDIRECT = (RUN & TAKEN) | (STALL & PEND_TAKEN).
- Simultaneous I_BUSYWAIT and D_BUSYWAIT are treated as one stall. The stall ends only when both are low.
- RETIRED wraps from 32'hFFFFFFFF to 0.
- Reset asserted at any time, including mid-stall:
  - Immediately forces PC=RESET_PC, state BOOT, RETIRED=0, pending cleared, STALL=0, FETCH_EN=0.
  - A pending redirect is discarded.
- Reset values: PC=RESET_PC, PC_PLUS4=RESET_PC+4, FETCH_EN=0, STALL=0, REDIRECT=0, RETIRED=0.

## Timing
- PC, state, RETIRED and pending registers update #1 after the rising edge of CLK.
- Asynchronous reset takes effect #1 after the RESET falling edge.
- PC_PLUS4 settles #1 after PC changes.
- TARGET settles #2 after PC_PLUS4 or OFFSET changes.
- Next-PC select has no delay.
- STALL, FETCH_EN and REDIRECT are combinational from state and inputs, with no delay.
- Latency:
  - A non-stalled instruction advances PC in one cycle.
  - A stall of N busy edges delays the advance by exactly N cycles.
  - After reset release there is exactly one BOOT cycle before the first fetch.
- Busywait is sampled only at the rising edge. Mid-cycle busywait pulses that are low at the edge have no effect.

## Structure
- Shared package cpu_pkg holds:
  - the state encoding (BOOT=2'b00, RUN=2'b01, STALL=2'b10);
  - the default RESET_PC constant;
  - the instruction offset bit positions.
- Sub-module pc_next_logic is purely combinational. It produces PC_PLUS4, TARGET and TAKEN with the delays stated in Timing, and contains no state.
- The top-level pc_sequencer holds the FSM, the PC register, the pending registers and the RETIRED counter.

## Test plan
- Reset/boot: hold RESET low for 3 cycles, then release.
  - Required: PC=0 and FETCH_EN=0 for the BOOT cycle.
  - Then, with no flow signals and no busywait, PC=4 after the second edge, PC=8 after the third, and RETIRED=2.
- Branch taken vs. not taken at PC=0x10, BRANCH=1, OFFSET=8'h02:
  - ZERO=1 gives PC=0x1C and REDIRECT=1.
  - ZERO=0 gives PC=0x14.
- Backward jump: PC=0x20, JUMP=1, OFFSET=8'hFE → PC=0x1C.
- Stall with pending jump: at PC=0x40, JUMP=1 and OFFSET=8'h03, with D_BUSYWAIT=1 for 4 edges.
  - JUMP drops to 0 during the stall.
  - Required: PC holds 0x40 and STALL=1 for 4 cycles, then PC=0x50 and RETIRED increments once.
- Overlapping busywaits: I_BUSYWAIT high for edges 1–2 and D_BUSYWAIT high for edges 2–5 → one continuous stall of 5 cycles, and PC advances once.
- Reset mid-stall and wrap-around:
  - Assert RESET during a stall with a pending target → PC=RESET_PC, pending cleared, BOOT re-entered.
  - Separately, force PC=0xFFFFFFFC with no flow → next PC=0x00000000.
